// File: rtl/module_hamming_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : module_hamming_tx_if
// Description : Bus bundle for the Hamming(7,4)+parity serial transmitter.
//               The master drives the data nibble, the error-injection
//               controls and the send request. The slave (the transmitter)
//               returns handshake status, the serial line, the latched
//               codeword and the end-of-frame pulse.
//   dato_i    [3:0] data nibble d3..d0
//   inyecta_i [1:0] error injection (00 none, 01 single, 10 double, 11 none)
//   pos_i     [2:0] bit position for the injected error
//   enviar_i        send request
//   listo_o         idle, ready to accept a send request
//   ocupado_o       frame in progress
//   tx_o            serial line, idles high
//   palabra_o [7:0] codeword of the current or last frame
//   fin_o           one-cycle pulse at frame completion
// Revision    : 1.0 - initial release
// ============================================================================
interface module_hamming_tx_if;
    logic [3:0] dato_i;
    logic [1:0] inyecta_i;
    logic [2:0] pos_i;
    logic       enviar_i;
    logic       listo_o;
    logic       ocupado_o;
    logic       tx_o;
    logic [7:0] palabra_o;
    logic       fin_o;

    modport master (
        output dato_i, inyecta_i, pos_i, enviar_i,
        input  listo_o, ocupado_o, tx_o, palabra_o, fin_o
    );

    modport slave (
        input  dato_i, inyecta_i, pos_i, enviar_i,
        output listo_o, ocupado_o, tx_o, palabra_o, fin_o
    );
endinterface
`default_nettype wire

// File: rtl/module_hamming_tx.sv
`default_nettype none
// ============================================================================
// Module      : module_hamming_tx
// Description : Builds an 8-bit SECDED codeword (Hamming(7,4) plus overall
//               parity) from a data nibble, optionally flips one or two
//               adjacent bits, and shifts the word out LSB first framed by
//               a start bit (0) and a stop bit (1).
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   module_hamming_tx_if.slave (see interface header for signals)
// Parameter   : CLKS_PER_BIT - clock cycles each serial bit is held (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module module_hamming_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    module_hamming_tx_if.slave    bus
);

    // Counter width; a single-cycle bit still needs a 1-bit counter.
    localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [c_CW-1:0]   cnt_q;
    logic [2:0]        idx_q;
    logic              tx_q;
    logic              fin_q;
    logic [7:0]        palabra_q;

    logic              w_p1;
    logic              w_p2;
    logic              w_p4;
    logic [7:1]        w_ham;
    logic [7:0]        w_codeword;
    logic [7:0]        w_mask;
    logic [7:0]        palabra_d;
    logic              w_last;
    logic [2:0]        w_idx_nxt;

    // Hamming positions 7..1 = d3 d2 d1 p4 d0 p2 p1; bit 0 makes parity even.
    assign w_p1       = bus.dato_i[0] ^ bus.dato_i[1] ^ bus.dato_i[3];
    assign w_p2       = bus.dato_i[0] ^ bus.dato_i[2] ^ bus.dato_i[3];
    assign w_p4       = bus.dato_i[1] ^ bus.dato_i[2] ^ bus.dato_i[3];
    assign w_ham      = {bus.dato_i[3], bus.dato_i[2], bus.dato_i[1], w_p4,
                         bus.dato_i[0], w_p2, w_p1};
    assign w_codeword = {w_ham, ^w_ham};

    // Double error uses the next position up; the 3-bit add wraps 7 -> 0.
    always_comb begin
        w_mask = 8'h00;
        case (bus.inyecta_i)
            2'b01:   w_mask = 8'h01 << bus.pos_i;
            2'b10:   w_mask = (8'h01 << bus.pos_i) | (8'h01 << (bus.pos_i + 3'd1));
            default: w_mask = 8'h00;
        endcase
    end

    assign palabra_d = w_codeword ^ w_mask;
    assign w_last    = (cnt_q == c_CW'(CLKS_PER_BIT - 1));
    assign w_idx_nxt = idx_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            tx_q      <= 1'b1;
            fin_q     <= 1'b0;
            palabra_q <= 8'h00;
        end else begin
            fin_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.enviar_i) begin
                        palabra_q <= palabra_d;
                        cnt_q     <= '0;
                        idx_q     <= 3'd0;
                        tx_q      <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (w_last) begin
                        cnt_q   <= '0;
                        idx_q   <= 3'd0;
                        tx_q    <= palabra_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + c_CW'(1);
                    end
                end
                DATA: begin
                    if (w_last) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            idx_q <= w_idx_nxt;
                            tx_q  <= palabra_q[w_idx_nxt];
                        end
                    end else begin
                        cnt_q <= cnt_q + c_CW'(1);
                    end
                end
                STOP: begin
                    if (w_last) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        fin_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + c_CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.listo_o   = (state_q == IDLE);
    assign bus.ocupado_o = (state_q != IDLE);
    assign bus.tx_o      = tx_q;
    assign bus.palabra_o = palabra_q;
    assign bus.fin_o     = fin_q;

endmodule
`default_nettype wire

// File: tb/tb_module_hamming_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_module_hamming_tx
// Description : Self-checking bench for module_hamming_tx. A frame-level
//               model (time since first low cycle, latched word) predicts
//               every output each cycle; directed scenarios add literal
//               expectations, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_module_hamming_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic rst;
    module_hamming_tx_if bus ();

    module_hamming_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] h;
        logic       par;
        h    = 8'h00;
        h[3] = d[0];
        h[5] = d[1];
        h[6] = d[2];
        h[7] = d[3];
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int j = 1; j < 8; j++)
                if (((j & p) != 0) && (j != p)) par ^= h[j];
            h[p] = par;
        end
        h[0] = ^h[7:1];
        return h;
    endfunction

    function automatic logic [7:0] err_mask(input logic [1:0] inj, input logic [2:0] pos);
        logic [7:0] m;
        int a, b;
        m = 8'h00;
        a = int'(pos);
        b = (a + 1) % 8;
        if (inj == 2'b01) m[a] = 1'b1;
        if (inj == 2'b10) begin
            m[a] = 1'b1;
            m[b] = 1'b1;
        end
        return m;
    endfunction

    bit         m_busy = 1'b0;
    int         m_t    = 0;
    logic [7:0] m_word = 8'h00;
    logic       m_fin  = 1'b0;

    always @(posedge clk) begin
        bit idle_before;
        if (rst) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_word = 8'h00;
            m_fin  = 1'b0;
        end else begin
            idle_before = !m_busy;
            m_fin       = 1'b0;
            if (m_busy) begin
                m_t++;
                if (m_t == FRAME) begin
                    m_busy = 1'b0;
                    m_fin  = 1'b1;
                end
            end
            if (idle_before && bus.enviar_i) begin
                m_word = encode(bus.dato_i) ^ err_mask(bus.inyecta_i, bus.pos_i);
                m_busy = 1'b1;
                m_t    = 0;
            end
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_word[k-1];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_o",      {7'd0, bus.tx_o},      {7'd0, exp_tx()});
            check("listo_o",   {7'd0, bus.listo_o},   {7'd0, !m_busy});
            check("ocupado_o", {7'd0, bus.ocupado_o}, {7'd0, m_busy});
            check("palabra_o", bus.palabra_o,         m_word);
            check("fin_o",     {7'd0, bus.fin_o},     {7'd0, m_fin});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [3:0] d, input logic [1:0] inj, input logic [2:0] pos);
        @(negedge clk);
        bus.dato_i    = d;
        bus.inyecta_i = inj;
        bus.pos_i     = pos;
        bus.enviar_i  = 1'b1;
        @(negedge clk);
        bus.enviar_i  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!bus.listo_o && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (!bus.listo_o) begin
            n_errors++;
            $display("FAIL %s: timeout waiting for listo_o, got 0 expected 1", nm);
        end
    endtask

    task automatic wait_fin(input string nm);
        int n;
        n = 0;
        while (!bus.fin_o && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (!bus.fin_o) begin
            n_errors++;
            $display("FAIL %s: timeout waiting for fin_o, got 0 expected 1", nm);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [9:0] t1_frame;
        t1_frame      = 10'b1_10101010_0;   // stop, word 8'hAA, start (LSB first)
        rst           = 1'b1;
        bus.dato_i    = 4'd0;
        bus.inyecta_i = 2'b00;
        bus.pos_i     = 3'd0;
        bus.enviar_i  = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_tx",      {7'd0, bus.tx_o},    8'd1);
        check("rst_listo",   {7'd0, bus.listo_o}, 8'd1);
        check("rst_palabra", bus.palabra_o,       8'h00);
        check("rst_fin",     {7'd0, bus.fin_o},   8'd0);

        // 1: 1011 -> AA, bit-exact waveform, fin at cycle 40
        send(4'b1011, 2'b00, 3'd0);
        check("t1_palabra", bus.palabra_o, 8'hAA);
        for (int i = 0; i < FRAME; i++) begin
            check("t1_tx_bit", {7'd0, bus.tx_o}, {7'd0, t1_frame[i / CPB]});
            @(negedge clk);
        end
        check("t1_fin",   {7'd0, bus.fin_o},   8'd1);
        check("t1_listo", {7'd0, bus.listo_o}, 8'd1);

        // 2: all-zero and all-one nibbles
        send(4'b0000, 2'b00, 3'd0);
        check("t2_zero", bus.palabra_o, 8'h00);
        wait_idle("t2_zero");
        send(4'b1111, 2'b00, 3'd0);
        check("t2_ones", bus.palabra_o, 8'hFF);
        wait_idle("t2_ones");

        // 3: error injection
        send(4'b1011, 2'b01, 3'd0);
        check("t3_single", bus.palabra_o, 8'hAB);
        wait_idle("t3_single");
        send(4'b1011, 2'b10, 3'd7);
        check("t3_double_wrap", bus.palabra_o, 8'h2B);
        wait_idle("t3_double_wrap");
        send(4'b1011, 2'b11, 3'd4);
        check("t3_none11", bus.palabra_o, 8'hAA);
        wait_idle("t3_none11");

        // 4: request while busy is ignored
        send(4'b1011, 2'b00, 3'd0);
        repeat (10) @(negedge clk);
        send(4'b0110, 2'b01, 3'd3);
        check("t4_palabra_held", bus.palabra_o, 8'hAA);
        wait_fin("t4_fin");
        repeat (3) @(negedge clk);
        check("t4_no_second", {7'd0, bus.listo_o}, 8'd1);

        // 5: enviar held high -> back-to-back frames
        @(negedge clk);
        bus.dato_i   = 4'b0101;
        bus.enviar_i = 1'b1;
        @(negedge clk);
        wait_fin("t5_fin");
        @(negedge clk);
        check("t5_gapless_start", {7'd0, bus.tx_o},    8'd0);
        check("t5_busy_again",    {7'd0, bus.listo_o}, 8'd0);
        bus.enviar_i = 1'b0;
        wait_idle("t5_second");

        // 6: reset during data bit 3
        send(4'b1011, 2'b00, 3'd0);
        repeat (4 * CPB + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_tx",      {7'd0, bus.tx_o},    8'd1);
        check("t6_listo",   {7'd0, bus.listo_o}, 8'd1);
        check("t6_palabra", bus.palabra_o,       8'h00);
        send(4'b1111, 2'b00, 3'd0);
        check("t6_resend", bus.palabra_o, 8'hFF);
        wait_idle("t6_resend");

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.dato_i    = 4'($urandom_range(0, 15));
            bus.inyecta_i = 2'($urandom_range(0, 3));
            bus.pos_i     = 3'($urandom_range(0, 7));
            bus.enviar_i  = ($urandom_range(0, 3) == 0);
            rst           = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.enviar_i = 1'b0;
        wait_idle("random_drain");
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/module_hamming_tx.md
Name: module_hamming_tx

Overview:
Transmit-side counterpart of the SECDED decoder and display path. It takes a 4-bit data nibble from the switches and builds a Hamming(7,4) codeword plus an overall parity bit (8 bits). It can optionally inject a single-bit or double-bit error into that codeword, then serialises the frame on one line with start and stop bits. The latched codeword is also exported so the display side can show what was sent.

Parameters:
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_o (legal range ≥1).

Ports:
clk  input  1  system clock; every register updates on the rising edge.
rst  input  1  synchronous, active-high reset.
dato_i  input  4  data nibble d3..d0.
inyecta_i  input  2  error injection: 00 none, 01 single, 10 double, 11 none.
pos_i  input  3  bit position (0-7) at which the error is injected.
enviar_i  input  1  send request, sampled only while listo_o=1.
listo_o  output  1  idle and able to accept a send request.
ocupado_o  output  1  frame in progress (always equal to ~listo_o).
tx_o  output  1  serial line, idles high.
palabra_o  output  8  codeword latched for the current or last frame, with any injected error applied.
fin_o  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Codeword layout: bit0 = p0 (overall parity); bits7..1 hold Hamming positions 7..1 = d3, d2, d1, p4, d0, p2, p1.
- Parity equations: p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3; p0 = XOR of bits7..1, so the 8-bit word has even parity.
- Error mask:
  - 01: 1<<pos_i.
  - 10: (1<<pos_i) | (1<<((pos_i+1) mod 8)); pos 7 wraps to bit 0.
  - 00 or 11: 0.
- Latching: palabra_o = codeword XOR mask. It is latched at the accepting edge only; dato_i, inyecta_i and pos_i are ignored at all other times.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: listo_o=1, tx_o=1. If enviar_i=1 at an edge, latch palabra_o, clear the bit counter and cycle counter, and go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o = palabra_o[idx] for CLKS_PER_BIT cycles per bit, LSB first. After idx 7 completes, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE and assert fin_o for exactly one cycle (the first IDLE cycle).
- tx_o is registered. It goes low in the cycle after the accepting edge.
- The full frame is 10*CLKS_PER_BIT cycles, measured from the first low cycle to the first IDLE cycle.
- Back-to-back frames: enviar_i may be accepted in the same cycle fin_o is high; tx_o then goes low the next cycle, giving no extra idle gap.
- enviar_i held high continuously produces consecutive frames, each sampling its inputs at its own acceptance edge.
- enviar_i asserted while busy is ignored, not queued.
- Reset values (also apply on reset mid-frame): state IDLE, tx_o=1, listo_o=1, ocupado_o=0, fin_o=0, palabra_o=8'h00, counters 0. A frame in progress is abandoned with no fin_o.
- If rst and enviar_i are high together, rst wins.

Test Plan:
1. Reset, then dato_i=4'b1011, inyecta_i=00, enviar_i pulsed for 1 cycle, CLKS_PER_BIT=4 → palabra_o=8'hAA; tx_o reads 0, 0,1,0,1,0,1,0,1, 1 with each level held 4 cycles; fin_o pulses at cycle 40 after the first low cycle; listo_o returns high.
2. dato_i=4'b0000 → palabra_o=8'h00. dato_i=4'b1111 → palabra_o=8'hFF. Both frames have even parity.
3. dato_i=4'b1011 with inyecta_i=01, pos_i=0 → palabra_o=8'hAB. With inyecta_i=10, pos_i=7 → palabra_o=8'h2B (wrap to bit 0). With inyecta_i=11 → 8'hAA.
4. Mid-frame, change dato_i and pulse enviar_i → no effect: frame bits and palabra_o unchanged, no second frame starts.
5. enviar_i held high for 2 frames → second start bit begins the cycle after fin_o, with no idle gap.
6. Assert rst during DATA bit 3 → next cycle tx_o=1, listo_o=1, palabra_o=8'h00, fin_o never pulses; a subsequent send works normally.
